// File: rtl/ifu.sv
// Instruction fetch unit: single-outstanding bus fetcher feeding an in-order buffer to decode.
// Define IFU_PREFETCH_EN for a 2-entry prefetch buffer; default build holds a single entry.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        jump_req_i,
  input  logic [31:0] jump_pc_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

`ifdef IFU_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  localparam logic [1:0]  DEPTH_CNT = 2'(DEPTH);
  localparam logic [31:0] RESET_FPC = RESET_PC & ~32'h3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DROP = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] fpc;
  logic [31:0] req_pc;
  logic [31:0] last_pc;
  logic [1:0]  count;
  logic [1:0]  count_nxt;
  logic [1:0]  wr_idx;
  logic        pop;
  logic        push;
  logic        room;

  logic [DEPTH-1:0][31:0] pc_buf;
  logic [DEPTH-1:0][31:0] inst_buf;
  logic [DEPTH-1:0][31:0] pc_buf_nxt;
  logic [DEPTH-1:0][31:0] inst_buf_nxt;

  // A redirect wins over both consumption and arrival of an instruction.
  assign pop       = (count != 2'd0) && !stall_i && !jump_req_i;
  assign push      = (state == WAIT) && ibus_rvalid_i && !jump_req_i;
  assign wr_idx    = count - {1'b0, pop};
  assign count_nxt = wr_idx + {1'b0, push};
  assign room      = count_nxt < DEPTH_CNT;

  assign ibus_req_o   = (state == REQ);
  assign ibus_addr_o  = fpc;
  assign inst_valid_o = (count != 2'd0);
  assign inst_o       = inst_valid_o ? inst_buf[0] : NOP_INST;
  assign pc_o         = inst_valid_o ? pc_buf[0] : last_pc;

  always_comb begin
    state_nxt = state;
    if (jump_req_i) begin
      case (state)
        IDLE:    state_nxt = REQ;
        REQ:     state_nxt = ibus_gnt_i ? DROP : REQ;
        // A response landing with the redirect retires the stale request.
        default: state_nxt = ibus_rvalid_i ? REQ : DROP;
      endcase
    end else begin
      case (state)
        IDLE:    state_nxt = room ? REQ : IDLE;
        REQ:     state_nxt = ibus_gnt_i ? WAIT : REQ;
        WAIT:    state_nxt = ibus_rvalid_i ? (room ? REQ : IDLE) : WAIT;
        default: state_nxt = ibus_rvalid_i ? REQ : DROP;
      endcase
    end
  end

  // Entry 0 is always the head; popping shifts the buffer down one slot.
  always_comb begin
    pc_buf_nxt   = pc_buf;
    inst_buf_nxt = inst_buf;
    if (pop) begin
      pc_buf_nxt   = pc_buf >> 32;
      inst_buf_nxt = inst_buf >> 32;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (wr_idx == 2'(i))) begin
        pc_buf_nxt[i]   = req_pc;
        inst_buf_nxt[i] = ibus_rdata_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      fpc      <= RESET_FPC;
      req_pc   <= RESET_FPC;
      last_pc  <= RESET_PC;
      count    <= 2'd0;
      pc_buf   <= '0;
      inst_buf <= '0;
    end else begin
      state    <= state_nxt;
      pc_buf   <= pc_buf_nxt;
      inst_buf <= inst_buf_nxt;
      if (jump_req_i) begin
        fpc   <= jump_pc_i & ~32'h3;
        count <= 2'd0;
      end else begin
        count <= count_nxt;
        if ((state == REQ) && ibus_gnt_i) begin
          fpc    <= fpc + 32'd4;
          req_pc <= fpc;
        end
      end
      // Remember the displayed PC so it stays put while the buffer is empty.
      if (count != 2'd0) begin
        last_pc <= pc_buf[0];
      end
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: per-cycle vector table plus reset-in-flight and stalled-stream sequences.
// Expectations adapt to IFU_PREFETCH_EN through the pf constant.
module tb_ifu;

`ifdef IFU_PREFETCH_EN
  localparam logic pf = 1'b1;
`else
  localparam logic pf = 1'b0;
`endif

  localparam logic [31:0] nop = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        jump;
  logic [31:0] jump_pc;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_valid;

  int checks = 0;
  int errors = 0;

  logic        pend;
  logic [31:0] pend_addr;
  int          grants;
  int          popped;
  logic [31:0] exp_pc;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        jump;
    logic [31:0] jump_pc;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } vec_t;

  vec_t vecs[29];

  ifu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall),
    .jump_req_i   (jump),
    .jump_pc_i    (jump_pc),
    .ibus_req_o   (ibus_req),
    .ibus_addr_o  (ibus_addr),
    .ibus_gnt_i   (gnt),
    .ibus_rvalid_i(rvalid),
    .ibus_rdata_i (rdata),
    .pc_o         (pc),
    .inst_o       (inst),
    .inst_valid_o (inst_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

  function automatic vec_t mk(input logic r, input logic s, input logic j, input logic [31:0] jp,
                              input logic g, input logic rv, input logic [31:0] rd,
                              input logic q, input logic [31:0] a, input logic v,
                              input logic [31:0] p, input logic [31:0] ins);
    vec_t t;
    t.rst_n = r;  t.stall = s;  t.jump = j;  t.jump_pc = jp;
    t.gnt = g;    t.rvalid = rv; t.rdata = rd;
    t.req = q;    t.addr = a;   t.valid = v; t.pc = p; t.inst = ins;
    return t;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h0050_0093;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t t);
    rst_n   = t.rst_n;
    stall   = t.stall;
    jump    = t.jump;
    jump_pc = t.jump_pc;
    gnt     = t.gnt;
    rvalid  = t.rvalid;
    rdata   = t.rdata;
  endtask

  // Bus responder with gnt tied high and rvalid one cycle after each grant.
  task automatic resp_cycle(input logic stall_v);
    @(negedge clk);
    rst_n  = 1'b1;
    jump   = 1'b0;
    stall  = stall_v;
    gnt    = 1'b1;
    rvalid = pend;
    rdata  = mem_word(pend_addr);
    #1;
    if (ibus_req) grants++;
    if (inst_valid && !stall_v) begin
      check_output($sformatf("stream%0d.pc", popped), pc, exp_pc);
      check_output($sformatf("stream%0d.inst", popped), inst, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      popped++;
    end
    pend      = ibus_req;
    pend_addr = ibus_addr;
  endtask

  initial begin
    // rst, stall, jump, jump_pc, gnt, rvalid, rdata | req, addr, valid, pc, inst
    vecs[0]  = mk(0,0,0,0,0,0,0,                1,0,0,0,nop);
    vecs[0].req = 1'b0;
    vecs[1]  = mk(1,0,0,0,0,0,0,                0,0,0,0,nop);
    vecs[2]  = mk(1,0,0,0,1,0,0,                1,0,0,0,nop);
    vecs[3]  = mk(1,1,0,0,0,1,32'h0050_0093,    0,0,0,0,nop);
    vecs[4]  = mk(1,1,0,0,0,0,0,                pf,32'h4,1,0,32'h0050_0093);
    vecs[5]  = mk(1,0,0,0,0,0,0,                pf,32'h4,1,0,32'h0050_0093);
    vecs[6]  = mk(1,0,0,0,1,0,0,                1,32'h4,0,0,nop);
    vecs[7]  = mk(1,0,0,0,0,1,32'h0010_0113,    0,0,0,0,nop);
    vecs[8]  = mk(1,0,0,0,0,0,0,                pf,32'h8,1,32'h4,32'h0010_0113);
    vecs[9]  = mk(1,0,0,0,1,0,0,                1,32'h8,0,32'h4,nop);
    vecs[10] = mk(1,0,1,32'h102,0,0,0,          0,0,0,32'h4,nop);
    vecs[11] = mk(1,0,0,0,0,1,32'hDEAD_BEEF,    0,0,0,32'h4,nop);
    vecs[12] = mk(1,0,0,0,1,0,0,                1,32'h100,0,32'h4,nop);
    vecs[13] = mk(1,1,0,0,0,1,32'h0000_0517,    0,0,0,32'h4,nop);
    vecs[14] = mk(1,1,0,0,1,0,0,                pf,32'h104,1,32'h100,32'h0000_0517);
    vecs[15] = mk(1,0,1,32'h200,0,pf,32'h1111_1111, 0,0,1,32'h100,32'h0000_0517);
    for (int i = 16; i <= 20; i++)
      vecs[i] = mk(1,0,0,0,0,0,0,               1,32'h200,0,32'h100,nop);
    vecs[21] = mk(1,0,0,0,1,0,0,                1,32'h200,0,32'h100,nop);
    vecs[22] = mk(1,1,0,0,0,1,32'h2222_2222,    0,0,0,32'h100,nop);
    vecs[23] = mk(1,1,1,32'h300,1,0,0,          pf,32'h204,1,32'h200,32'h2222_2222);
    vecs[24] = mk(1,0,0,0,0,pf,32'h3333_3333,   !pf,32'h300,0,32'h200,nop);
    vecs[25] = mk(1,0,0,0,1,0,0,                1,32'h300,0,32'h200,nop);
    vecs[26] = mk(1,0,0,0,0,1,32'h4444_4444,    0,0,0,32'h200,nop);
    vecs[27] = mk(1,0,0,0,0,0,0,                pf,32'h304,1,32'h300,32'h4444_4444);
    vecs[28] = mk(1,0,0,0,0,0,0,                1,32'h304,0,32'h300,nop);

    apply_stimulus(vecs[0]);
    repeat (2) @(posedge clk);

    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      apply_stimulus(vecs[i]);
      #1;
      check_output($sformatf("v%0d.req", i), {31'b0, ibus_req}, {31'b0, vecs[i].req});
      if (vecs[i].req)
        check_output($sformatf("v%0d.addr", i), ibus_addr, vecs[i].addr);
      check_output($sformatf("v%0d.valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].valid});
      check_output($sformatf("v%0d.pc", i), pc, vecs[i].pc);
      check_output($sformatf("v%0d.inst", i), inst, vecs[i].inst);
    end

    // Reset lands while a request is outstanding; its late response must be ignored.
    @(negedge clk);
    gnt = 1'b1; stall = 1'b0; jump = 1'b0; rvalid = 1'b0;
    @(negedge clk);
    gnt = 1'b0;
    #1;
    check_output("rst_wait.req", {31'b0, ibus_req}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; rvalid = 1'b1; rdata = 32'hBAD0_BAD0;
    #1;
    check_output("rst_rel.req", {31'b0, ibus_req}, 32'd0);
    check_output("rst_rel.valid", {31'b0, inst_valid}, 32'd0);
    check_output("rst_rel.pc", pc, 32'h0);
    check_output("rst_rel.inst", inst, nop);
    @(negedge clk);
    rvalid = 1'b0; gnt = 1'b1;
    #1;
    check_output("rst_req.req", {31'b0, ibus_req}, 32'd1);
    check_output("rst_req.addr", ibus_addr, 32'h0);
    check_output("rst_req.valid", {31'b0, inst_valid}, 32'd0);
    @(negedge clk);
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0050_0093;
    #1;
    check_output("rst_wait2.req", {31'b0, ibus_req}, 32'd0);
    @(negedge clk);
    rvalid = 1'b0; stall = 1'b1;
    #1;
    check_output("rst_first.valid", {31'b0, inst_valid}, 32'd1);
    check_output("rst_first.pc", pc, 32'h0);
    check_output("rst_first.inst", inst, 32'h0050_0093);

    // Stalled decode: count grants, then release and confirm an unbroken PC stream.
    @(negedge clk);
    rst_n = 1'b0; gnt = 1'b0; rvalid = 1'b0; stall = 1'b1; jump = 1'b0;
    @(negedge clk);
    pend = 1'b0; pend_addr = 32'h0; grants = 0; popped = 0; exp_pc = 32'h0;
    for (int i = 0; i < 12; i++) resp_cycle(1'b1);
    check_output("stall.grants", grants, pf ? 32'd2 : 32'd1);
    check_output("stall.req", {31'b0, ibus_req}, 32'd0);
    check_output("stall.valid", {31'b0, inst_valid}, 32'd1);
    for (int i = 0; i < 60 && popped < 5; i++) resp_cycle(1'b0);
    check_output("stream.count", popped, 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), driven on inst_o when no valid instruction is held.
REQ-003 Port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 Port rst_n, input, 1, reset; synchronous and active-low.
REQ-005 Port stall_i, input, 1, from ctrl; when high, the IF/ID consumer does not accept the current instruction.
REQ-006 Port jump_req_i, input, 1, from the decode stage; redirects fetch (already stall-qualified upstream).
REQ-007 Port jump_pc_i, input, 32, redirect target.
REQ-008 Port ibus_req_o, input/output direction output, 1, fetch request valid.
REQ-009 Port ibus_addr_o, output, 32, fetch word address, bits [1:0] always 0.
REQ-010 Port ibus_gnt_i, input, 1, request accepted when ibus_req_o & ibus_gnt_i.
REQ-011 Port ibus_rvalid_i, input, 1, read data valid; responses in order, at least 1 cycle after grant.
REQ-012 Port ibus_rdata_i, input, 32, fetched instruction word.
REQ-013 Port pc_o, output, 32, PC of the instruction on inst_o.
REQ-014 Port inst_o, output, 32, instruction to the decode stage.
REQ-015 Port inst_valid_o, output, 1, inst_o/pc_o hold a real fetched instruction.

Function
REQ-016 The block keeps fetch PC fpc, an in-order instruction buffer of DEPTH entries, and an FSM with states IDLE, REQ, WAIT, DROP.
REQ-017 At most one request is outstanding; ibus_req_o is high only in REQ, with ibus_addr_o = fpc.
REQ-018 REQ is entered only while buffer occupancy < DEPTH; otherwise the FSM holds in IDLE.
REQ-019 REQ + gnt -> WAIT, fpc <= fpc + 4; REQ without gnt -> stay, address held stable unless redirected.
REQ-020 WAIT + rvalid -> push {fpc_of_request, ibus_rdata_i} into buffer; next state REQ if room after push, else IDLE.
REQ-021 Buffer head drives pc_o/inst_o; inst_valid_o = buffer non-empty; empty -> inst_o = NOP_INST, pc_o = last head PC.
REQ-022 The head is popped when inst_valid_o & !stall_i; push and pop in the same cycle keep occupancy unchanged.
REQ-023 A response may be pushed into an empty buffer and appear on inst_o the next cycle (fetch-to-output latency: grant + response + 1).
REQ-024 jump_req_i high: buffer cleared, fpc <= {jump_pc_i[31:2],2'b00}, inst_valid_o low next cycle.
REQ-025 Jump in IDLE or REQ (granted or not) -> REQ next cycle with new fpc; a request granted in that same cycle -> DROP instead.
REQ-026 Jump in WAIT without rvalid -> DROP; with rvalid in same cycle -> response discarded, REQ next.
REQ-027 DROP: ibus_req_o low; rvalid discards data and -> REQ; jump in DROP updates fpc, stays DROP.
REQ-028 Jump has priority over pop and push in the same cycle.

Reset
REQ-029 With rst_n low at a clock edge: state <= IDLE, fpc <= RESET_PC, buffer emptied, inst_valid_o = 0, inst_o = NOP_INST, pc_o = RESET_PC, ibus_req_o = 0.
REQ-030 Reset mid-transaction abandons any outstanding request; a response arriving in the first post-reset cycle is ignored (IDLE does not accept rvalid).
REQ-031 First request issued in the second cycle after rst_n rises (IDLE -> REQ).

Configuration
REQ-032 Macro IFU_PREFETCH_EN defined: DEPTH = 2, fetching continues while the decode stage is stalled until the buffer is full.
REQ-033 Macro undefined: DEPTH = 1, next request issued only when the single entry is popped in the same cycle or empty; all other rules unchanged.

Verification
REQ-034 Reset release, gnt always 1, rvalid 1 cycle after grant, mem[0]=32'h00500093 -> inst_o = 32'h00500093, pc_o = 0, inst_valid_o = 1 four cycles after rst_n rises; following PCs 4, 8, 12.
REQ-035 stall_i held high 10 cycles with IFU_PREFETCH_EN -> exactly 2 grants accumulate, then ibus_req_o low; without macro -> 1 grant; no instruction lost or duplicated on release.
REQ-036 jump_req_i with jump_pc_i = 32'h0000_0102 while in WAIT -> that response discarded, next grant address 32'h0000_0100, first valid pc_o = 32'h100.
REQ-037 jump_req_i coincident with rvalid and a pop -> pop and push suppressed, inst_valid_o = 0 next cycle, next ibus_addr_o = target.
REQ-038 gnt held low 5 cycles during REQ -> ibus_addr_o stable, ibus_req_o stays high, no fpc advance.
REQ-039 rst_n asserted in WAIT, rvalid arrives first cycle after release -> ignored, first grant at RESET_PC, pc_o = RESET_PC with correct data.
